// File: rtl/sar_magnitude_search_pkg.sv
// sar_magnitude_search_pkg
// Shared definitions for the successive-approximation magnitude search:
//   - state_t       : FSM state encodings S_IDLE / S_SEARCH / S_DONE
//   - flags_onehot  : true when exactly one comparator flag is asserted
package sar_magnitude_search_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // A consistent comparator raises exactly one of gt/eq/lt. The XOR is
    // true for one or three flags high; the AND term rejects the three case.
    function automatic logic flags_onehot(input logic gt, input logic eq, input logic lt);
        return (gt ^ eq ^ lt) && !(gt && eq && lt);
    endfunction

endpackage

// File: rtl/sar_magnitude_search.sv
// sar_magnitude_search
// Successive-approximation search that drives the probe operand of an external
// magnitude comparator and recovers the comparator's target value MSB first.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        launch a search (accepted in IDLE or DONE, ignored in SEARCH)
//   cmp_gt       comparator flag: target >  probe
//   cmp_eq       comparator flag: target == probe
//   cmp_lt       comparator flag: target <  probe
//   probe        operand driven to the comparator; 0 outside SEARCH
//   busy         high while searching
//   done         one-cycle pulse when result/err/probe_count are valid
//   result       recovered target, held until the next start
//   err          inconsistent comparator flags seen, held until the next start
//   probe_count  number of probes used by the last search, held
module sar_magnitude_search
    import sar_magnitude_search_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    input  logic             cmp_lt,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic [CW-1:0]    probe_count
);

    // Bit index needs at least one bit even for a 1-bit search.
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [WIDTH-1:0] PROBE_MSB = WIDTH'(1) << (WIDTH - 1);
    localparam logic [WIDTH-1:0] BIT0_MASK = ~WIDTH'(1);
    localparam logic [IW-1:0]    IDX_TOP   = IW'(WIDTH - 1);
    localparam logic [IW-1:0]    IDX_ONE   = IW'(1);

    state_t          state;
    logic [IW-1:0]   idx;

    // NOTE: every register here is updated with non-blocking assignments so all
    // outputs change together at the edge; blocking assignments would let later
    // statements see half-updated state and break the registered-output timing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            probe       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            err         <= 1'b0;
            probe_count <= '0;
        end else begin
            // done is a pulse: it only stays high when a search finishes this edge.
            done <= 1'b0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_SEARCH;
                        idx         <= IDX_TOP;
                        probe       <= PROBE_MSB;
                        busy        <= 1'b1;
                        result      <= '0;
                        err         <= 1'b0;
                        probe_count <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_SEARCH: begin
                    // The probe being judged this edge counts, deciding or not.
                    probe_count <= probe_count + CW'(1);

                    if (!flags_onehot(cmp_gt, cmp_eq, cmp_lt)) begin
                        err    <= 1'b1;
                        result <= probe;
                        state  <= S_DONE;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        probe  <= '0;
                    end else if (cmp_eq) begin
                        result <= probe;
                        state  <= S_DONE;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        probe  <= '0;
                    end else if (cmp_lt) begin
                        if (idx == '0) begin
                            // Last bit was too high: the answer is the probe without it.
                            result <= probe & BIT0_MASK;
                            state  <= S_DONE;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            probe  <= '0;
                        end else begin
                            probe[idx]           <= 1'b0;
                            probe[idx - IDX_ONE] <= 1'b1;
                            idx                  <= idx - IDX_ONE;
                        end
                    end else begin
                        if (idx == '0) begin
                            // target > probe with every bit already decided cannot
                            // come from a consistent comparator.
                            err    <= 1'b1;
                            result <= probe;
                            state  <= S_DONE;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            probe  <= '0;
                        end else begin
                            probe[idx - IDX_ONE] <= 1'b1;
                            idx                  <= idx - IDX_ONE;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    probe <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_magnitude_search.sv
// tb_sar_magnitude_search
// Closed-loop bench: a behavioural comparator compares the bench target with the
// DUT probe. Expected probe sequences come from an arithmetic binary-search
// model; fault injection overrides the flags on a chosen probe value.
module tb_sar_magnitude_search;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          cmp_gt, cmp_eq, cmp_lt;
    logic [W-1:0]  probe;
    logic          busy, done, err;
    logic [W-1:0]  result;
    logic [CW-1:0] probe_count;

    logic [W-1:0]  target;
    logic          force_en;
    logic [W-1:0]  force_probe;
    logic [2:0]    force_flags;   // {gt, eq, lt}

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sar_magnitude_search #(.WIDTH(W), .CW(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cmp_gt      (cmp_gt),
        .cmp_eq      (cmp_eq),
        .cmp_lt      (cmp_lt),
        .probe       (probe),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .err         (err),
        .probe_count (probe_count)
    );

    // Comparator model with optional flag override on one probe value.
    always_comb begin
        cmp_gt = (target > probe);
        cmp_eq = (target == probe);
        cmp_lt = (target < probe);
        if (force_en && busy && probe == force_probe)
            {cmp_gt, cmp_eq, cmp_lt} = force_flags;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: classic binary search on the integer range, using add/subtract
    // of a halving step. Returns the probe values tried and how many.
    function automatic void model(input int t, output int n, output int seq[W]);
        int step = 1 << (W - 1);
        int p    = step;
        n = 0;
        for (int i = 0; i < W; i++) seq[i] = 0;
        while (n < W) begin
            seq[n] = p;
            n++;
            if (t == p || step == 1) break;
            if (t < p) p = p - step + step / 2;
            else       p = p + step / 2;
            step = step / 2;
        end
    endfunction

    // Called at a negedge: request a search; returns at the negedge after the
    // accepting edge, when probe 1 should be visible.
    task automatic start_search(input logic [W-1:0] t);
        target = t;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Walks the search until done (bounded), checking each probe against the
    // model sequence. poke raises start on the 2nd probe to show it is ignored.
    task automatic wait_done(input string name, input int seq[W], input int exp_n,
                             input bit poke, output int cycles);
        int k = 0;
        check({name, "_done_low_first"}, 32'(done), 32'd0);
        while (!done && k < W + 2) begin
            if (k < exp_n) check($sformatf("%s_probe%0d", name, k + 1), 32'(probe), 32'(seq[k]));
            check($sformatf("%s_busy%0d", name, k + 1), 32'(busy), 32'd1);
            if (poke && k == 1) start = 1'b1;
            if (poke && k == 2) start = 1'b0;
            k++;
            @(negedge clk);
        end
        start  = 1'b0;
        cycles = k;
        check({name, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic verify(input string name, input logic [W-1:0] exp_res, input bit exp_err,
                          input int exp_cnt, input int cycles);
        check({name, "_cycles"}, 32'(cycles), 32'(exp_cnt));
        check({name, "_busy_at_done"}, 32'(busy), 32'd0);
        check({name, "_probe_at_done"}, 32'(probe), 32'd0);
        check({name, "_result"}, 32'(result), 32'(exp_res));
        check({name, "_err"}, 32'(err), 32'(exp_err));
        check({name, "_count"}, 32'(probe_count), 32'(exp_cnt));
    endtask

    // After a done pulse with no new start: back to idle, outputs held.
    task automatic verify_idle(input string name, input logic [W-1:0] exp_res, input bit exp_err,
                               input int exp_cnt);
        @(negedge clk);
        check({name, "_done_pulse_end"}, 32'(done), 32'd0);
        check({name, "_idle_busy"}, 32'(busy), 32'd0);
        check({name, "_idle_probe"}, 32'(probe), 32'd0);
        check({name, "_held_result"}, 32'(result), 32'(exp_res));
        check({name, "_held_err"}, 32'(err), 32'(exp_err));
        check({name, "_held_count"}, 32'(probe_count), 32'(exp_cnt));
    endtask

    typedef struct {
        logic [W-1:0] target;
        logic [W-1:0] exp_result;
        bit           exp_err;
        int           exp_count;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   seq[W];
        int   n;
        int   cycles;

        vecs[0] = '{target: 4'd11, exp_result: 4'd11, exp_err: 1'b0, exp_count: 4};
        vecs[1] = '{target: 4'd0,  exp_result: 4'd0,  exp_err: 1'b0, exp_count: 4};
        vecs[2] = '{target: 4'd15, exp_result: 4'd15, exp_err: 1'b0, exp_count: 4};
        vecs[3] = '{target: 4'd8,  exp_result: 4'd8,  exp_err: 1'b0, exp_count: 1};
        vecs[4] = '{target: 4'd4,  exp_result: 4'd4,  exp_err: 1'b0, exp_count: 2};
        vecs[5] = '{target: 4'd6,  exp_result: 4'd6,  exp_err: 1'b0, exp_count: 3};

        rst_n       = 1'b0;
        start       = 1'b0;
        target      = '0;
        force_en    = 1'b0;
        force_probe = '0;
        force_flags = 3'b000;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_probe", 32'(probe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_count", 32'(probe_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            string nm = $sformatf("vec%0d_t%0d", i, vecs[i].target);
            model(int'(vecs[i].target), n, seq);
            start_search(vecs[i].target);
            wait_done(nm, seq, n, 1'b0, cycles);
            verify(nm, vecs[i].exp_result, vecs[i].exp_err, vecs[i].exp_count, cycles);
            verify_idle(nm, vecs[i].exp_result, vecs[i].exp_err, vecs[i].exp_count);
        end

        // Random targets against the model
        for (int i = 0; i < 12; i++) begin
            logic [W-1:0] t = W'($urandom_range(15, 0));
            string nm = $sformatf("rnd%0d_t%0d", i, t);
            model(int'(t), n, seq);
            start_search(t);
            wait_done(nm, seq, n, 1'b0, cycles);
            verify(nm, t, 1'b0, n, cycles);
        end
        @(negedge clk);

        // Fault: gt and lt together on probe 2 (12)
        force_en = 1'b1; force_probe = 4'd12; force_flags = 3'b101;
        model(13, n, seq);
        start_search(4'd13);
        wait_done("fault_gtlt", seq, 2, 1'b0, cycles);
        verify("fault_gtlt", 4'd12, 1'b1, 2, cycles);
        verify_idle("fault_gtlt", 4'd12, 1'b1, 2);

        // Fault: gt on the final probe (15)
        force_probe = 4'd15; force_flags = 3'b100;
        model(15, n, seq);
        start_search(4'd15);
        wait_done("fault_final_gt", seq, n, 1'b0, cycles);
        verify("fault_final_gt", 4'd15, 1'b1, 4, cycles);

        // Fault: no flag on the first probe; back-to-back start from DONE
        force_probe = 4'd8; force_flags = 3'b000;
        model(3, n, seq);
        start_search(4'd3);
        wait_done("fault_none", seq, 1, 1'b0, cycles);
        verify("fault_none", 4'd8, 1'b1, 1, cycles);
        force_en = 1'b0;
        @(negedge clk);

        // start pulsed mid-search is ignored
        model(5, n, seq);
        start_search(4'd5);
        wait_done("mid_start", seq, n, 1'b1, cycles);
        verify("mid_start", 4'd5, 1'b0, 4, cycles);
        verify_idle("mid_start", 4'd5, 1'b0, 4);

        // Reset during probe 3
        model(9, n, seq);
        start_search(4'd9);
        @(negedge clk);
        @(negedge clk);
        check("rstmid_probe3", 32'(probe), 32'(seq[2]));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rstmid_probe", 32'(probe), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        check("rstmid_result", 32'(result), 32'd0);
        check("rstmid_err", 32'(err), 32'd0);
        check("rstmid_count", 32'(probe_count), 32'd0);
        @(negedge clk);

        // Exhaustive back-to-back: each start is held high in the DONE cycle
        for (int t = 0; t < 16; t++) begin
            string nm = $sformatf("b2b_t%0d", t);
            model(t, n, seq);
            start_search(W'(t));
            wait_done(nm, seq, n, 1'b0, cycles);
            verify(nm, W'(t), 1'b0, n, cycles);
        end
        verify_idle("b2b_last", 4'd15, 1'b0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sar_magnitude_search.md
# sar_magnitude_search

Successive-approximation search engine that drives the probe operand of an external magnitude comparator and consumes its gt/eq/lt flags to recover an unknown target value bit by bit. It is the consumer side of the comparator interface.
- The comparator evaluates target (operand a) against probe (operand b) combinationally.
- This block sequences probes and reports the found value.
- Used for threshold discovery and ADC-style conversion loops.

## Interface
- WIDTH, 4: operand width in bits; probes per search ≤ WIDTH
- CW, $clog2(WIDTH+1): width of probe_count
- clk  input  1  rising-edge clock; the block uses one clock
- rst_n  input  1  synchronous, active-low reset
- start  input  1  launches a search when sampled high in IDLE or DONE
- cmp_gt  input  1  comparator flag: target > probe
- cmp_eq  input  1  comparator flag: target == probe
- cmp_lt  input  1  comparator flag: target < probe
- probe  output  WIDTH  operand driven to the comparator; 0 outside SEARCH
- busy  output  1  high while in SEARCH
- done  output  1  one-cycle pulse when result/err/probe_count are valid
- result  output  WIDTH  recovered target; held until next start
- err  output  1  inconsistent comparator flags seen; held until next start
- probe_count  output  CW  number of probes used in the last search; held

## Operation
- The FSM has three states.
  - IDLE: probe=0, busy=0, done=0. If start=1, go to SEARCH, with bit index = WIDTH-1, probe = 1<<(WIDTH-1), and probe_count cleared.
  - SEARCH: busy=1. Flags are sampled each clock against the current probe.
    - More than one flag high, or none high: err=1, result=probe, go to DONE.
    - cmp_eq: result=probe, go to DONE.
    - cmp_lt: clear the current bit. If the index is 0, result = probe with bit0 cleared and go to DONE. Otherwise set the next lower bit in probe and decrement the index.
    - cmp_gt: keep the current bit. If the index is 0, this is impossible for a consistent comparator: err=1, result=probe, go to DONE. Otherwise set the next lower bit.
    - probe_count increments on every sampled probe, including the deciding probe.
  - DONE: done=1 for exactly one cycle, then return to IDLE. If start=1 in DONE, go directly to SEARCH; done still pulses this cycle.
- start is ignored while in SEARCH.
- Flags are ignored outside SEARCH.
- Width rules:
  - probe/result are unsigned WIDTH bits.
  - Arithmetic is bit set/clear only; there is no add/subtract and no wrap.
  - probe_count saturation is never needed, since the maximum is WIDTH.

## Timing
- Reset (rst_n=0 at a clock edge): state IDLE, probe=0, busy=0, done=0, result=0, err=0, probe_count=0. This applies mid-search too; outputs are reset-valued in the cycle after the edge.
- The comparator path is combinational from probe to flags. Probe is registered and updated only at clock edges, so each probe lasts one cycle.
- Latency for a search that decides on probe k (1 ≤ k ≤ WIDTH):
  - start sampled at edge E0.
  - Probe 1 is visible after E0.
  - done is high in the cycle after edge Ek.
  - Worst case is done in the cycle after E(WIDTH).
- result, err and probe_count update at the same edge that asserts done.
- These three outputs are cleared at the start-accepting edge.

## Structure
- Shared package/header holds:
  - FSM state encodings S_IDLE, S_SEARCH, S_DONE as localparams.
  - The flag one-hot check as a function.
- Single module; no sub-module is required.
- The comparator is external. The bench instantiates the team's existing 4-bit magnitude comparator with a = bench target and b = probe, closing the loop.

## Test plan
All scenarios use WIDTH=4 and a closed loop with a comparator model.
1. target=11 → probes 8,12,10,11 (flags gt,lt,gt,eq) → done in cycle 4 after start, result=11, err=0, probe_count=4.
2. target=0 → probes 8,4,2,1 all lt → result=0, err=0, probe_count=4. target=15 → probes 8,12,14,15 → eq at probe 4, result=15.
3. target=8 → eq on first probe → done 1 cycle after E1, probe_count=1, busy low the cycle done is high.
4. Forced faults:
   - Bench drives gt and lt together on probe 2 (12) → done next cycle, err=1, result=12, probe_count=2.
   - gt forced on final probe → err=1.
5. Control and reset:
   - start pulsed mid-search is ignored and the result is unchanged.
   - start held high in the DONE cycle starts a new search with probe=8 next cycle.
   - rst_n=0 during probe 3 → next cycle probe=0, busy=0, result=0, err=0, probe_count=0.
6. Exhaustive targets 0..15, each back-to-back → result==target, err=0, probe_count≤4, done exactly one cycle per search.
